// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - parametrised bank of configurable counters with register access
module counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter bit RST_EN = 1'b1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [2:0]              cfg_reg_i,
  input  logic [WIDTH-1:0]        cfg_wdata_i,
  input  logic                    rd_req_i,
  input  logic [CH_W-1:0]         rd_ch_i,
  input  logic [2:0]              rd_reg_i,
  output logic                    rd_valid_o,
  output logic [WIDTH-1:0]        rd_data_o,
  input  logic                    snapshot_i,
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       match_o,
  output logic                    irq_o
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD   = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_SNAP   = 3'd4;

  // CTRL bit positions
  localparam int C_EN = 0, C_DOWN = 1, C_SAT = 2, C_AR = 3, C_IRQ = 4;

  logic [WIDTH-1:0]  r_count  [NUM_CH];
  logic [WIDTH-1:0]  r_reload [NUM_CH];
  logic [WIDTH-1:0]  r_cmp    [NUM_CH];
  logic [WIDTH-1:0]  r_snap   [NUM_CH];
  logic [4:0]        r_ctrl   [NUM_CH];
  logic [1:0]        r_status [NUM_CH];
  logic              r_irq;
  logic              r_rd_valid;
  logic [WIDTH-1:0]  r_rd_data;

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_match;
  logic [NUM_CH-1:0] w_match_set;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_irq_src;
  logic [WIDTH-1:0]  w_count_nxt  [NUM_CH];
  logic [1:0]        w_status_nxt [NUM_CH];
  logic [WIDTH-1:0]  w_rd_data;

  // Decode the write strobe into a per-channel select; out-of-range indices select nothing
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c] = cfg_we_i && (int'(cfg_ch_i) == c);
    end
  end

  // Per-channel counter step and sticky status next-state, LOAD write has top priority
  always_comb begin
    w_match     = '0;
    w_match_set = '0;
    w_ovf_set   = '0;
    w_irq_src   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_match[c]      = (r_count[c] == r_cmp[c]);
      w_count_nxt[c]  = r_count[c];
      w_status_nxt[c] = r_status[c];
      if (w_sel[c] && cfg_reg_i == REG_LOAD) begin
        w_count_nxt[c] = cfg_wdata_i;
      end else if (r_ctrl[c][C_EN]) begin
        w_match_set[c] = w_match[c];
        if (r_ctrl[c][C_AR] && w_match[c]) begin
          w_count_nxt[c] = r_reload[c];
        end else if (!r_ctrl[c][C_DOWN]) begin
          if (r_count[c] == {WIDTH{1'b1}}) begin
            w_ovf_set[c]   = 1'b1;
            w_count_nxt[c] = r_ctrl[c][C_SAT] ? r_count[c] : '0;
          end else begin
            w_count_nxt[c] = r_count[c] + 1'b1;
          end
        end else begin
          if (r_count[c] == '0) begin
            w_ovf_set[c]   = 1'b1;
            w_count_nxt[c] = r_ctrl[c][C_SAT] ? r_count[c] : {WIDTH{1'b1}};
          end else begin
            w_count_nxt[c] = r_count[c] - 1'b1;
          end
        end
      end
      // Clear first, then set, so a same-cycle set survives the W1C
      if (w_sel[c] && cfg_reg_i == REG_STATUS) begin
        w_status_nxt[c] = r_status[c] & ~cfg_wdata_i[1:0];
      end
      w_status_nxt[c] = w_status_nxt[c] | {w_ovf_set[c], w_match_set[c]};
      w_irq_src[c]    = r_ctrl[c][C_IRQ] & (|r_status[c]);
    end
  end

  // Channel state registers: counters, config, status and snapshot shadows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_count[c]  <= '0;
        r_reload[c] <= '0;
        r_cmp[c]    <= {WIDTH{1'b1}};
        r_snap[c]   <= '0;
        r_ctrl[c]   <= {4'b0000, RST_EN};
        r_status[c] <= 2'b00;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_count[c]  <= w_count_nxt[c];
        r_status[c] <= w_status_nxt[c];
        if (snapshot_i) r_snap[c] <= r_count[c];
        if (w_sel[c]) begin
          case (cfg_reg_i)
            REG_CTRL: r_ctrl[c]   <= cfg_wdata_i[4:0];
            REG_LOAD: r_reload[c] <= cfg_wdata_i;
            REG_CMP:  r_cmp[c]    <= cfg_wdata_i;
            default:  ;
          endcase
        end
      end
    end
  end

  // Read mux over current register values; unmapped registers and channels read 0
  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_ch_i) == c) begin
        case (rd_reg_i)
          REG_CTRL:   w_rd_data = WIDTH'(r_ctrl[c]);
          REG_LOAD:   w_rd_data = r_count[c];
          REG_CMP:    w_rd_data = r_cmp[c];
          REG_STATUS: w_rd_data = WIDTH'(r_status[c]);
          REG_SNAP:   w_rd_data = r_snap[c];
          default:    w_rd_data = '0;
        endcase
      end
    end
  end

  // One-cycle read response; data holds between reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req_i;
      if (rd_req_i) r_rd_data <= w_rd_data;
    end
  end

  // Interrupt follows the registered status one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_irq <= 1'b0;
    else         r_irq <= |w_irq_src;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count_out
    assign count_o[g*WIDTH +: WIDTH] = r_count[g];
  end

  assign match_o    = w_match;
  assign irq_o      = r_irq;
  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard testbench for counter_bank
module tb_counter_bank;
  localparam int NUM_CH = 5;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 3;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    cfg_we_i = 1'b0;
  logic [CH_W-1:0]         cfg_ch_i = '0;
  logic [2:0]              cfg_reg_i = '0;
  logic [WIDTH-1:0]        cfg_wdata_i = '0;
  logic                    rd_req_i = 1'b0;
  logic [CH_W-1:0]         rd_ch_i = '0;
  logic [2:0]              rd_reg_i = '0;
  logic                    rd_valid_o;
  logic [WIDTH-1:0]        rd_data_o;
  logic                    snapshot_i = 1'b0;
  logic [NUM_CH*WIDTH-1:0] count_o;
  logic [NUM_CH-1:0]       match_o;
  logic                    irq_o;

  counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .RST_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_reg_i(cfg_reg_i), .cfg_wdata_i(cfg_wdata_i),
    .rd_req_i(rd_req_i), .rd_ch_i(rd_ch_i), .rd_reg_i(rd_reg_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .snapshot_i(snapshot_i), .count_o(count_o), .match_o(match_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int c);
    return 64'(count_o[c*WIDTH +: WIDTH]);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int ch, input int rg, input int data);
    cfg_we_i    = 1'b1;
    cfg_ch_i    = CH_W'(ch);
    cfg_reg_i   = 3'(rg);
    cfg_wdata_i = WIDTH'(data);
    step();
    cfg_we_i    = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, input int exp);
    rd_req_i = 1'b1;
    rd_ch_i  = CH_W'(ch);
    rd_reg_i = 3'(rg);
    sb_q.push_back(64'(exp));
    step();
    rd_req_i = 1'b0;
  endtask

  // Read responses are compared against the scoreboard away from the active edge
  always @(negedge clk_i) begin
    if (rd_valid_o === 1'b1) begin
      if (sb_q.size() == 0) check("rd_unexpected_valid", 64'(rd_valid_o), 64'd0);
      else                  check("rd_data", 64'(rd_data_o), sb_q.pop_front());
    end
  end

  int seq [8] = '{1, 2, 3, 4, 5, 1, 2, 3};

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("rst_rd_data", 64'(rd_data_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_match", 64'(match_o), 64'd0);
    rst_ni = 1'b1;

    // Free-running after reset release
    for (int k = 1; k <= 10; k++) begin
      step();
      for (int c = 0; c < NUM_CH; c++) check("t1_count", lane(c), 64'(k));
    end
    rd(0, 1, 10);
    check("t1_irq", 64'(irq_o), 64'd0);
    for (int c = 0; c < NUM_CH; c++) wr(c, 0, 0);

    // Up-count wrap with overflow and interrupt
    wr(1, 2, 8'h80);
    wr(1, 1, 8'hFE);
    check("t2_load", lane(1), 64'hFE);
    wr(1, 0, 8'h11);
    check("t2_fe", lane(1), 64'hFE);
    step();
    check("t2_ff", lane(1), 64'hFF);
    step();
    check("t2_wrap", lane(1), 64'h00);
    check("t2_irq_lag", 64'(irq_o), 64'd0);
    step();
    check("t2_irq_set", 64'(irq_o), 64'd1);
    rd(1, 3, 2);
    wr(1, 3, 2);
    check("t2_irq_after_w1c", 64'(irq_o), 64'd1);
    step();
    check("t2_irq_drop", 64'(irq_o), 64'd0);
    wr(1, 0, 0);

    // Down-count saturation, set beats concurrent W1C
    wr(2, 1, 2);
    wr(2, 0, 8'h07);
    check("t3_2", lane(2), 64'd2);
    step();
    check("t3_1", lane(2), 64'd1);
    step();
    check("t3_0", lane(2), 64'd0);
    cfg_we_i = 1'b1; cfg_ch_i = 3'd2; cfg_reg_i = 3'd3; cfg_wdata_i = 8'h02;
    rd(2, 3, 0);
    cfg_we_i = 1'b0;
    check("t3_hold0", lane(2), 64'd0);
    rd(2, 3, 2);
    check("t3_hold0b", lane(2), 64'd0);

    // Compare with auto-reload
    wr(0, 2, 5);
    wr(0, 1, 1);
    wr(0, 0, 8'h09);
    for (int i = 0; i < 8; i++) begin
      check("t4_count", lane(0), 64'(seq[i]));
      check("t4_match", 64'(match_o[0]), 64'(seq[i] == 5));
      if (i < 7) step();
    end
    rd(0, 3, 1);
    check("t4_irq", 64'(irq_o), 64'd0);
    wr(0, 0, 0);
    wr(2, 0, 0);

    // Snapshot concurrent with LOAD captures the pre-load value
    wr(0, 1, 8'h10);
    wr(1, 1, 8'h21);
    wr(2, 1, 8'h32);
    wr(4, 1, 8'h54);
    wr(3, 1, 97);
    wr(3, 0, 1);
    check("t5_97", lane(3), 64'd97);
    repeat (3) step();
    check("t5_100", lane(3), 64'd100);
    snapshot_i = 1'b1;
    wr(3, 1, 7);
    snapshot_i = 1'b0;
    check("t5_7", lane(3), 64'd7);
    step();
    check("t5_8", lane(3), 64'd8);
    rd(0, 4, 8'h10);
    rd(1, 4, 8'h21);
    rd(2, 4, 8'h32);
    rd(3, 4, 100);
    rd(4, 4, 8'h54);

    // Unmapped registers and channels
    wr(0, 6, 8'hFF);
    wr(6, 2, 8'h77);
    wr(5, 0, 8'h1F);
    wr(0, 5, 8'hAA);
    rd(0, 6, 0);
    rd(5, 2, 0);
    rd(7, 1, 0);
    rd(0, 5, 0);
    rd(1, 2, 8'h80);
    rd(5, 0, 0);
    rd(0, 0, 0);
    rd(0, 2, 5);
    repeat (2) step();
    check("t6_rd_hold", 64'(rd_data_o), 64'd5);
    check("t6_rd_idle", 64'(rd_valid_o), 64'd0);

    // Asynchronous reset mid-count drops an in-flight read
    wr(2, 0, 8'h10);
    step();
    check("t7_irq_pre", 64'(irq_o), 64'd1);
    rd_req_i = 1'b1; rd_ch_i = 3'd3; rd_reg_i = 3'd1;
    step();
    rd_req_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("t7_count", 64'(count_o), 64'd0);
    check("t7_rd_valid", 64'(rd_valid_o), 64'd0);
    check("t7_rd_data", 64'(rd_data_o), 64'd0);
    check("t7_irq", 64'(irq_o), 64'd0);
    check("t7_match", 64'(match_o), 64'd0);
    step();
    rst_ni = 1'b1;
    repeat (2) step();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised bank of NUM_CH free-running counters: the successor to the single fixed 32-bit DUT counter used by infrastructure-level tests.
- Each channel has:
  - enable, direction, and wrap/saturate mode
  - load value, compare threshold with optional auto-reload
  - sticky status flags and an interrupt enable
- A simple register port configures the bank; a read port has fixed 1-cycle latency; a global snapshot captures all channels in the same cycle.
- Sits behind the infrastructure's register demux as a richer DUT for address-map, interrupt and scan tests.

Parameters:
- NUM_CH, 4: number of counter channels, 1..16.
- WIDTH, 32: counter/data width, 8..64.
- RST_EN, 1: reset value of every channel's CTRL.en (1 keeps legacy free-running behaviour).
- CH_W, $clog2(NUM_CH) min 1: derived channel-index width; not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  register write strobe, single cycle
- cfg_ch_i  in  CH_W  write channel index
- cfg_reg_i  in  3  write register select
- cfg_wdata_i  in  WIDTH  write data
- rd_req_i  in  1  read request
- rd_ch_i  in  CH_W  read channel index
- rd_reg_i  in  3  read register select
- rd_valid_o  out  1  read data valid, one cycle after rd_req_i
- rd_data_o  out  WIDTH  read data
- snapshot_i  in  1  capture all counters into shadow registers
- count_o  out  NUM_CH*WIDTH  live counters, channel 0 in LSBs
- match_o  out  NUM_CH  combinational count_q==cmp_q per channel
- irq_o  out  1  OR of enabled sticky status bits

Behaviour:
- Register map, per channel:
  - 0 CTRL, RW: bit0 en, bit1 down, bit2 sat, bit3 autoreload, bit4 irq_en; other bits read 0.
  - 1 LOAD, W / COUNT, R: a write sets count_q and reload_q to wdata; a read returns live count_q.
  - 2 CMP, RW.
  - 3 STATUS: bit0 match, bit1 ovf; write-1-to-clear.
  - 4 SNAP, RO: snapshot value.
  - Regs 5-7, or channel >= NUM_CH: writes ignored, reads return 0 with rd_valid_o still asserted.
- Reset values:
  - count_q=0, reload_q=0, cmp_q=all-ones, snap_q=0
  - CTRL=RST_EN in bit0 only; STATUS=0
  - rd_valid_o=0, rd_data_o=0, irq_o=0
- Counter update, per channel, each cycle, in priority order:
  1. LOAD write to this channel: count_q <= wdata. No step, no match or ovf set this cycle.
  2. en=1 and autoreload=1 and count_q==cmp_q: count_q <= reload_q; STATUS.match set.
  3. en=1, up (down=0):
     - count_q==max with sat=0: wrap to 0, set ovf.
     - count_q==max with sat=1: hold max, set ovf.
     - otherwise +1.
  4. en=1, down (down=1):
     - count_q==0 with sat=0: wrap to max, set ovf.
     - count_q==0 with sat=1: hold 0, set ovf.
     - otherwise -1.
  5. en=0: hold.
- STATUS.match is also set whenever en=1 and count_q==cmp_q, without autoreload; the counter then steps normally.
- All arithmetic is modulo 2^WIDTH.
- Status flags are sticky until cleared by W1C.
  - A set and a W1C of the same bit in the same cycle: set wins.
  - W1C of 0 bits has no effect.
- irq_o is registered: irq_o <= OR over channels of (irq_en & (match|ovf)). It follows status with 1 cycle latency.
- snapshot_i: snap_q[c] <= count_q[c] for all channels in the same edge, i.e. the pre-update value. Snapshot concurrent with LOAD captures the old value.
- Reads:
  - rd_valid_o is registered from rd_req_i, so back-to-back reads are supported at one per cycle.
  - rd_data_o reflects register values before the update of the request cycle.
  - rd_data_o holds its last value when rd_valid_o=0.
- Writes and reads to the same register in the same cycle: the read returns the old value.
- CTRL changes take effect on the counter from the next cycle.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Any read in flight is dropped (rd_valid_o=0).

Test Plan:
1. Reset release, RST_EN=1, no writes → each count_o lane = 0,1,2,… on successive edges; rd COUNT ch0 after 10 cycles returns 9 or 10, matching the live value at the request edge; irq_o=0.
2. WIDTH=8, ch1 LOAD 0xFE, CTRL=en|irq_en → counts 0xFE,0xFF,0x00; STATUS.ovf=1; irq_o=1 one cycle after the flag; W1C STATUS=0x2 → ovf=0 and irq_o drops next cycle.
3. ch2 CTRL=en|down|sat, LOAD 2 → 2,1,0,0,0; ovf set on the first held cycle; a concurrent W1C on that cycle leaves ovf=1.
4. ch0 CMP=5, LOAD 1, CTRL=en|autoreload → 1,2,3,4,5,1,2,…; match_o pulses while count=5; STATUS.match=1.
5. snapshot_i while ch3 counts 100 and a LOAD 7 to ch3 occurs in the same cycle → SNAP ch3 reads 100, COUNT then 7,8,…; other channels' SNAP equal their same-edge counts.
6. Reads to reg 6 and to channel NUM_CH (NUM_CH=3) → rd_valid_o=1, data 0; writes there change nothing. Assert rst_ni mid-count → all outputs 0 immediately.
